// File: rtl/mat_mul_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier.
// Holds the controller state encoding and the accumulator width function.
package mat_mul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Width needed to sum cols_a full-width products without overflow.
    function automatic int acc_width(input int data_width, input int cols_a);
        return 2 * data_width + $clog2(cols_a);
    endfunction

endpackage

// File: rtl/dot_prod.sv
// One row of A times one column of B, signed or unsigned, reduced to DATA_WIDTH.
// Reduction wraps by default; defining MAT_MUL_SAT_EN makes it saturate.
module dot_prod
    import mat_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COLS_A     = 4
) (
    input  logic [COLS_A-1:0][DATA_WIDTH-1:0] a_row_i,
    input  logic [COLS_A-1:0][DATA_WIDTH-1:0] b_col_i,
    input  logic                              signed_i,
    output logic [DATA_WIDTH-1:0]             result_o
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COLS_A);

`ifdef MAT_MUL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Upper accumulator bits filled in when sign-extending a negative product.
    localparam logic [ACC_WIDTH-1:0]  HI_MASK = ~ACC_WIDTH'({PROD_WIDTH{1'b1}});
    localparam logic [DATA_WIDTH-1:0] S_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] S_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [PROD_WIDTH-1:0] a_ext;
    logic [PROD_WIDTH-1:0] b_ext;
    logic [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]  sum;

    // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        prod  = '0;
        sum   = '0;
        for (int k = 0; k < COLS_A; k++) begin
            a_ext = {{DATA_WIDTH{signed_i & a_row_i[k][DATA_WIDTH-1]}}, a_row_i[k]};
            b_ext = {{DATA_WIDTH{signed_i & b_col_i[k][DATA_WIDTH-1]}}, b_col_i[k]};
            prod  = a_ext * b_ext;
            sum   = sum + (ACC_WIDTH'(prod) |
                           ((signed_i && prod[PROD_WIDTH-1]) ? HI_MASK : '0));
        end

        result_o = sum[DATA_WIDTH-1:0];
        if (SAT_EN) begin
            if (signed_i) begin
                // In range only when every bit above the result sign matches it.
                if (!((&sum[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|sum[ACC_WIDTH-1:DATA_WIDTH-1]))) begin
                    result_o = sum[ACC_WIDTH-1] ? S_MIN : S_MAX;
                end
            end else if (|sum[ACC_WIDTH-1:DATA_WIDTH]) begin
                result_o = '1;
            end
        end
    end

endmodule

// File: rtl/mat_mul_seq.sv
// Sequential C = A x B: captures operands, computes LANES columns of C per cycle, holds C until consumed.
// Optional MAT_MUL_SAT_EN selects saturating instead of wrapping element reduction.
module mat_mul_seq
    import mat_mul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_A     = 4,
    parameter int COLS_A     = 4,
    parameter int COLS_B     = 4,
    parameter int LANES      = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a [ROWS_A][COLS_A],
    input  logic [DATA_WIDTH-1:0] b [COLS_A][COLS_B],
    input  logic                  signed_mode,
    output logic [DATA_WIDTH-1:0] c [ROWS_A][COLS_B],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int COL_W = (COLS_B > 1) ? $clog2(COLS_B) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS_B - LANES);
    localparam logic [COL_W-1:0] COL_STEP = COL_W'(LANES);

    if (COLS_B % LANES != 0) begin : g_lanes_check
        $error("mat_mul_seq: LANES must divide COLS_B");
    end

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  accept;
    logic                  signed_q;
    logic [DATA_WIDTH-1:0] a_q [ROWS_A][COLS_A];
    logic [DATA_WIDTH-1:0] b_q [COLS_A][COLS_B];
    logic [DATA_WIDTH-1:0] c_q [ROWS_A][COLS_B];

    logic [COLS_A-1:0][DATA_WIDTH-1:0] row_vec [ROWS_A];
    logic [COLS_A-1:0][DATA_WIDTH-1:0] col_vec [LANES];
    logic [DATA_WIDTH-1:0]             lane_res [ROWS_A][LANES];

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = COMPUTE;
                    col_d   = '0;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (col_q == LAST_COL) begin
                    state_d = HOLD;
                    col_d   = '0;
                end else begin
                    col_d = col_q + COL_STEP;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // NOTE: operand copies are pure datapath, always written before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
        end
    end

    // Route the captured row and the current LANES columns to the dot-product array.
    always_comb begin
        for (int r = 0; r < ROWS_A; r++) begin
            for (int k = 0; k < COLS_A; k++) begin
                row_vec[r][k] = a_q[r][k];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < COLS_A; k++) begin
                col_vec[l][k] = '0;
                for (int j = 0; j < COLS_B; j++) begin
                    if (j == int'(col_q) + l) begin
                        col_vec[l][k] = b_q[k][j];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < ROWS_A; r++) begin : g_row
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            dot_prod #(
                .DATA_WIDTH (DATA_WIDTH),
                .COLS_A     (COLS_A)
            ) u_dot_prod (
                .a_row_i  (row_vec[r]),
                .b_col_i  (col_vec[l]),
                .signed_i (signed_q),
                .result_o (lane_res[r][l])
            );
        end
    end

    // Result is user-visible, so it is cleared on reset to hide any partial product.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < ROWS_A; r++) begin
                for (int j = 0; j < COLS_B; j++) begin
                    c_q[r][j] <= '0;
                end
            end
        end else if (state_q == COMPUTE) begin
            for (int r = 0; r < ROWS_A; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    for (int j = 0; j < COLS_B; j++) begin
                        if (j == int'(col_q) + l) begin
                            c_q[r][j] <= lane_res[r][l];
                        end
                    end
                end
            end
        end
    end

    assign c = c_q;

endmodule
